// File: rtl/vliw_imm_pkg.sv
// vliw_imm_pkg: immediate kinds, widths and opcode match constants for the VLIW immediate stage
package vliw_imm_pkg;
  localparam int INSTR_W = 16;
  localparam int IMM_W = 32;
  localparam logic [2:0] OPC_SEXT11 = 3'b111;
  localparam logic [3:0] OPC_SEXT8 = 4'b1101;
  localparam logic [2:0] OPC_ZEXT8 = 3'b001;
  typedef enum logic [1:0] {
    IMM_NONE   = 2'b00,
    IMM_ZEXT8  = 2'b01,
    IMM_SEXT8  = 2'b10,
    IMM_SEXT11 = 2'b11
  } imm_kind_t;
endpackage

// File: rtl/imm_slot_decode.sv
// imm_slot_decode: classifies one 16-bit instruction and extends its immediate to 32 bits (i_instr -> o_kind, o_imm)
module imm_slot_decode
  import vliw_imm_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output imm_kind_t          o_kind,
  output logic [IMM_W-1:0]   o_imm
);
  always_comb begin
    o_kind = i_instr[15:13] == OPC_SEXT11 ? IMM_SEXT11 :
             i_instr[15:12] == OPC_SEXT8  ? IMM_SEXT8  :
             i_instr[15:13] == OPC_ZEXT8  ? IMM_ZEXT8  : IMM_NONE;
    o_imm  = o_kind == IMM_SEXT11 ? {{21{i_instr[10]}}, i_instr[10:0]} :
             o_kind == IMM_SEXT8  ? {{24{i_instr[7]}}, i_instr[7:0]}   :
             o_kind == IMM_ZEXT8  ? {24'b0, i_instr[7:0]}              : '0;
  end
endmodule

// File: rtl/vliw_imm_stage.sv
// vliw_imm_stage: per-slot immediate decode registered behind a valid/ready handshake with a 2-entry skid buffer
// in: clk, reset, flush, in_valid/in_bundle/in_pc, out_ready; out: in_ready, out_valid/out_pc/out_imm/out_kind
module vliw_imm_stage
  import vliw_imm_pkg::*;
#(
  parameter int NUM_SLOTS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTR_W*NUM_SLOTS-1:0] in_bundle,
  input  logic [31:0]                  in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_pc,
  output logic [IMM_W*NUM_SLOTS-1:0]   out_imm,
  output logic [2*NUM_SLOTS-1:0]       out_kind
);
  logic [IMM_W*NUM_SLOTS-1:0] w_imm;
  logic [2*NUM_SLOTS-1:0]     w_kind;
  logic                       w_in_fire;
  logic                       w_out_fire;
  logic                       r_in_ready;
  logic                       r_main_valid;
  logic [31:0]                r_main_pc;
  logic [IMM_W*NUM_SLOTS-1:0] r_main_imm;
  logic [2*NUM_SLOTS-1:0]     r_main_kind;
  logic                       r_skid_valid;
  logic [31:0]                r_skid_pc;
  logic [IMM_W*NUM_SLOTS-1:0] r_skid_imm;
  logic [2*NUM_SLOTS-1:0]     r_skid_kind;
  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    imm_kind_t w_k;
    imm_slot_decode u_dec (
      .i_instr(in_bundle[s*INSTR_W +: INSTR_W]),
      .o_kind (w_k),
      .o_imm  (w_imm[s*IMM_W +: IMM_W])
    );
    assign w_kind[2*s +: 2] = w_k;
  end
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_main_valid & out_ready;
  assign in_ready   = r_in_ready;
  assign out_valid  = r_main_valid;
  assign out_pc     = r_main_pc;
  assign out_imm    = r_main_imm;
  assign out_kind   = r_main_kind;
  // in_ready is kept as the registered complement of skid occupancy, so a
  // stalled downstream never reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_in_ready   <= 1'b1;
      r_main_valid <= 1'b0;
      r_main_pc    <= '0;
      r_main_imm   <= '0;
      r_main_kind  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_imm   <= '0;
      r_skid_kind  <= '0;
    end else if (w_out_fire && r_skid_valid) begin
      r_main_pc    <= r_skid_pc;
      r_main_imm   <= r_skid_imm;
      r_main_kind  <= r_skid_kind;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_in_fire && (!r_main_valid || w_out_fire)) begin
      r_main_valid <= 1'b1;
      r_main_pc    <= in_pc;
      r_main_imm   <= w_imm;
      r_main_kind  <= w_kind;
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_pc    <= in_pc;
      r_skid_imm   <= w_imm;
      r_skid_kind  <= w_kind;
      r_in_ready   <= 1'b0;
    end else if (w_out_fire) begin
      r_main_valid <= 1'b0;
    end
  end
endmodule

// File: doc/vliw_imm_stage.md
# vliw_imm_stage

Decode-side immediate stage of the VLIW pipeline. Each cycle it can accept one fetched bundle of 16-bit instructions. For every slot it classifies the immediate format, then extracts and extends the offset to 32 bits: sign-extend 8, sign-extend 11, or zero-extend 8. The stage registers the results behind a valid/ready handshake with a 2-entry skid buffer, so the register-read/execute stage sees one extended immediate per slot with one cycle of latency and full throughput.

## Interface
Parameters:
- NUM_SLOTS, 2, number of 16-bit instruction slots per bundle. Slot k occupies `in_bundle[16k+15:16k]`.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (branch redirect); clears all held bundles.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept a bundle; registered.
- in_bundle  in  16*NUM_SLOTS  fetched instruction bundle.
- in_pc  in  32  bundle PC.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  32  PC of the output bundle.
- out_imm  out  32*NUM_SLOTS  extended immediate per slot; slot k occupies `[32k+31:32k]`.
- out_kind  out  2*NUM_SLOTS  immediate kind per slot: 00 NONE, 01 ZEXT8, 10 SEXT8, 11 SEXT11.

## Operation
Per-slot classification uses instruction i[15:0] and is evaluated in this priority order:
- i[15:13]=111 → SEXT11. Imm = {21{i[10]}, i[10:0]}. The sign bit is bit 10, not bit 7.
- i[15:12]=1101 → SEXT8. Imm = {24{i[7]}, i[7:0]}.
- i[15:13]=001 → ZEXT8. Imm = {24'b0, i[7:0]}.
- Otherwise → NONE, and imm = 32'h0.

Extension is purely arithmetic. There is no shift or scaling, and the stage never adds PC.

Buffering:
- Main register: holds the output-facing data.
- Skid register: one extra entry.
- A transfer happens on any cycle where valid and ready are both high.
- in_ready = !skid_valid, driven from a register.

Cases when an input transfer occurs:
- If main is empty, or main is being drained this cycle while skid is empty, the input loads main.
- If main is full and not draining, the input loads skid, and in_ready drops the next cycle.
- When main drains and skid is full, skid moves to main and skid empties. An input cannot arrive in that cycle because in_ready=0.

Ordering and data rules:
- Bundle order is preserved.
- No bundle is dropped or duplicated except on flush.
- While out_valid=1 and out_ready=0, the out_* data stays stable.

Reset and flush:
- Reset or flush clears main_valid and skid_valid.
- After either: out_valid=0, in_ready=1.
- Also after either: out_pc, out_imm and out_kind = 0.
- An input presented in the same cycle as a flush is discarded.
- Reset has priority; flush and reset have the same effect.

## Timing
- Latency: in_valid&in_ready at edge N → out_valid=1 with that bundle's data after edge N.
- Throughput: one bundle per cycle while out_ready=1.
- Stall: out_ready low for one cycle while input keeps streaming fills skid. in_ready goes low one cycle later, and no data is lost.
- Recovery: in_ready returns high the cycle after skid drains into main.
- All outputs come from registers. There is no combinational path from in_* to out_*.
- out_ready→in_ready has no combinational path; the skid entry covers the one-cycle lag.

## Structure
- Package vliw_imm_pkg holds:
  - the imm_kind_t enum (NONE/ZEXT8/SEXT8/SEXT11);
  - INSTR_W=16 and IMM_W=32;
  - opcode match constants (OPC_SEXT11=3'b111, OPC_SEXT8=4'b1101, OPC_ZEXT8=3'b001).
- Sub-module imm_slot_decode: a combinational classify-and-extend unit for one slot, taking 16-bit in and producing {kind, imm32}. It is instantiated NUM_SLOTS times ahead of the main/skid registers.

## Test plan
- **Mixed bundle:** in_bundle=32'h2080_E7FF, out_ready=1 → next cycle slot0 kind=11 imm=32'hFFFF_FFFF, slot1 kind=01 imm=32'h0000_0080.
- **Sign-bit position:**
  - 16'hE080 → SEXT11, imm=32'h0000_0080 (bit 7 must not sign-extend).
  - 16'hE3FF → 32'h0000_03FF.
  - 16'hD0F0 → SEXT8, 32'hFFFF_FFF0.
  - 16'h4123 → NONE, 0.
- **Backpressure:**
  - Stimulus: stream PCs 0x100, 0x104, 0x108; out_ready=0 for 2 cycles, then 1.
  - Required: in_ready falls one cycle after skid fills; outputs appear as 0x100, 0x104, 0x108 in order; out_* stay stable during the stall.
- **Flush:** with main and skid both full, assert flush (and in_valid=1) → next cycle out_valid=0, in_ready=1, outputs 0, and the flushed-cycle input is absent from the output.
- **Reset mid-stream:** reset during back-to-back traffic → out_valid=0, in_ready=1, out_imm=0 after the edge; the first post-reset bundle emerges with 1-cycle latency.
- **Random streaming:** random in_valid/out_ready for 10k cycles → scoreboard shows no loss, no duplication, and in-order delivery.
